// File: rtl/inst_encoder.sv
`timescale 1ns/1ps
// inst_encoder: turns {op, rd, rs1, rs2, imm} requests into RV32I instruction
// words and buffers them in a 2-entry FIFO. Illegal ops and out-of-range
// immediates produce a flagged NOP. Also keeps request and error counters.
module inst_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [15:0] enc_cnt,
    output logic [7:0]  err_cnt
);

    typedef enum logic [2:0] {
        OP_JAL  = 3'd0,
        OP_BEQ  = 3'd1,
        OP_BLT  = 3'd2,
        OP_LW   = 3'd3,
        OP_ADDI = 3'd4,
        OP_SW   = 3'd5
    } op_e;

    localparam logic [31:0]        NOP_INST = 32'h0000_0013;
    localparam logic signed [31:0] IS_MIN   = -32'sd2048;
    localparam logic signed [31:0] IS_MAX   = 32'sd2047;
    localparam logic signed [31:0] B_MIN    = -32'sd4096;
    localparam logic signed [31:0] B_MAX    = 32'sd4094;
    localparam logic signed [31:0] J_MIN    = -32'sd1048576;
    localparam logic signed [31:0] J_MAX    = 32'sd1048574;

    logic signed [31:0] imm_s;
    logic               fit_is, fit_b, fit_j;
    logic               enc_ok;
    logic [31:0]        enc_word;
    logic [31:0]        enc_inst;
    logic               enc_err;

    logic [32:0]        fifo_mem [2];
    logic               rd_ptr, wr_ptr;
    logic [1:0]         count;
    logic               alive;
    logic               push, pop;

    assign imm_s  = $signed(in_imm);
    assign fit_is = (imm_s >= IS_MIN) && (imm_s <= IS_MAX);
    assign fit_b  = (imm_s >= B_MIN) && (imm_s <= B_MAX) && !in_imm[0];
    assign fit_j  = (imm_s >= J_MIN) && (imm_s <= J_MAX) && !in_imm[0];

    // Encode the current request: pick the format, place fields, validate the immediate.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        enc_ok   = 1'b0;
        enc_word = NOP_INST;
        case (op_e'(in_op))
            OP_JAL: begin
                enc_ok   = fit_j;
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, 7'b1101111};
            end
            OP_BEQ: begin
                enc_ok   = fit_b;
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                            in_imm[4:1], in_imm[11], 7'b1100011};
            end
            OP_BLT: begin
                enc_ok   = fit_b;
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b100,
                            in_imm[4:1], in_imm[11], 7'b1100011};
            end
            OP_LW: begin
                enc_ok   = fit_is;
                enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
            end
            OP_ADDI: begin
                enc_ok   = fit_is;
                enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
            end
            OP_SW: begin
                enc_ok   = fit_is;
                enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
            end
            default: begin
                enc_ok   = 1'b0;
                enc_word = NOP_INST;
            end
        endcase
        enc_err  = !enc_ok;
        enc_inst = enc_ok ? enc_word : NOP_INST;
    end

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready  = alive && (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_inst  = fifo_mem[rd_ptr][31:0];
    assign out_err   = fifo_mem[rd_ptr][32];

    // FIFO storage: write the encoded result into the tail slot on a push.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the storage is reset because the head slot drives the outputs, which must read 0 in reset.
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else if (push) begin
            fifo_mem[wr_ptr] <= {enc_err, enc_inst};
        end
    end

    // FIFO pointers, occupancy and the post-reset ready enable.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            alive  <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Accepted-request counter (wrapping) and error counter (saturating at 255).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_cnt <= 16'd0;
            err_cnt <= 8'd0;
        end else if (push) begin
            enc_cnt <= enc_cnt + 16'd1;
            if (enc_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
`timescale 1ns/1ps
// Bench for inst_encoder: directed vector table, backpressure and reset
// sequences, random traffic and counter limits, all scored against a
// queue-based reference model.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] enc_cnt;
    logic [7:0]  err_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    // reference model state
    logic [32:0] mq[$];
    int          m_enc = 0;
    int          m_err = 0;
    bit          m_alive = 1'b0;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] inst;
        logic        err;
        int          errc;
    } vec_t;
    vec_t vecs[$];

    inst_encoder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_err(out_err),
        .enc_cnt(enc_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            if (tests_failed <= 40)
                $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic longint place(longint unsigned u, int src_lo, int width, int dst_lo);
        longint unsigned field;
        field = (u >> src_lo) & ((64'd1 << width) - 64'd1);
        return longint'(field << dst_lo);
    endfunction

    // Reference encoder: range rules with integer arithmetic, fields summed in by weight.
    function automatic logic [32:0] ref_encode(logic [2:0] op, logic [4:0] rd, logic [4:0] rs1,
                                               logic [4:0] rs2, logic [31:0] imm);
        longint          v;
        longint unsigned u;
        longint          lo, hi, w;
        int              fmt, align, opc, f3;
        bit              use_rd, use_rs1, use_rs2;
        v = longint'($signed(imm));
        u = imm;
        use_rd = 0; use_rs1 = 0; use_rs2 = 0; f3 = 0;
        case (op)
            3'd0: begin fmt = 3; opc = 'h6F; use_rd = 1; end
            3'd1: begin fmt = 2; opc = 'h63; use_rs1 = 1; use_rs2 = 1; end
            3'd2: begin fmt = 2; opc = 'h63; f3 = 4; use_rs1 = 1; use_rs2 = 1; end
            3'd3: begin fmt = 0; opc = 'h03; f3 = 2; use_rd = 1; use_rs1 = 1; end
            3'd4: begin fmt = 0; opc = 'h13; use_rd = 1; use_rs1 = 1; end
            3'd5: begin fmt = 1; opc = 'h23; f3 = 2; use_rs1 = 1; use_rs2 = 1; end
            default: return {1'b1, 32'h0000_0013};
        endcase
        if (fmt <= 1)      begin lo = -2048;    hi = 2047;    align = 1; end
        else if (fmt == 2) begin lo = -4096;    hi = 4094;    align = 2; end
        else               begin lo = -1048576; hi = 1048574; align = 2; end
        if (v < lo || v > hi || (v % align) != 0) return {1'b1, 32'h0000_0013};
        w = opc + f3 * 4096;
        if (use_rd)  w += rd  * 128;
        if (use_rs1) w += rs1 * 32768;
        if (use_rs2) w += rs2 * 1048576;
        case (fmt)
            0: w += place(u, 0, 12, 20);
            1: w += place(u, 5, 7, 25) + place(u, 0, 5, 7);
            2: w += place(u, 12, 1, 31) + place(u, 5, 6, 25) + place(u, 1, 4, 8) + place(u, 11, 1, 7);
            default: w += place(u, 20, 1, 31) + place(u, 1, 10, 21) + place(u, 11, 1, 20) + place(u, 12, 8, 12);
        endcase
        return {1'b0, w[31:0]};
    endfunction

    task automatic compare_model();
        check("in_ready", {31'd0, in_ready}, {31'd0, (m_alive && mq.size() < 2)});
        check("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() != 0)});
        if (mq.size() != 0) begin
            check("out_inst", out_inst, mq[0][31:0]);
            check("out_err", {31'd0, out_err}, {31'd0, mq[0][32]});
        end
        check("enc_cnt", {16'd0, enc_cnt}, m_enc);
        check("err_cnt", {24'd0, err_cnt}, m_err);
    endtask

    // One clock: predict the handshake from model state, advance, compare #1 after the edge.
    task automatic cycle();
        bit          acc, pop;
        logic [32:0] r;
        acc = rst_n && in_valid && m_alive && (mq.size() < 2);
        pop = rst_n && (mq.size() != 0) && out_ready;
        r   = ref_encode(in_op, in_rd, in_rs1, in_rs2, in_imm);
        @(posedge clk);
        if (rst_n) begin
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(r);
                m_enc = (m_enc + 1) % 65536;
                if (r[32] && m_err < 255) m_err++;
            end
            m_alive = 1'b1;
        end
        #1;
        compare_model();
    endtask

    task automatic set_req(input bit v, input logic [2:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input int imm);
        in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    task automatic model_reset();
        mq.delete();
        m_enc = 0; m_err = 0; m_alive = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_inst"}, out_inst, 32'd0);
        check({tag, "_out_err"}, {31'd0, out_err}, 32'd0);
        check({tag, "_enc_cnt"}, {16'd0, enc_cnt}, 32'd0);
        check({tag, "_err_cnt"}, {24'd0, err_cnt}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic add_vec(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input int imm, input logic [31:0] inst,
                           input logic err, input int errc);
        vec_t t;
        t.op = op; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm;
        t.inst = inst; t.err = err; t.errc = errc;
        vecs.push_back(t);
    endtask

    initial begin
        int bnd[18] = '{-1048577, -1048576, -4097, -4096, -2049, -2048, -1, 0, 1,
                        2046, 2047, 2048, 4094, 4095, 4096, 1048574, 1048575, 1048576};

        // op, rd, rs1, rs2, imm, expected inst, expected err, expected err_cnt
        add_vec(3'd4, 5'd1, 5'd0, 5'd0, 5,        32'h0050_0093, 1'b0, 0);
        add_vec(3'd5, 5'd5, 5'd1, 5'd2, 8,        32'h0020_A423, 1'b0, 0);
        add_vec(3'd1, 5'd3, 5'd1, 5'd2, -4,       32'hFE20_8EE3, 1'b0, 0);
        add_vec(3'd0, 5'd0, 5'd7, 5'd9, 8,        32'h0080_006F, 1'b0, 0);
        add_vec(3'd4, 5'd1, 5'd0, 5'd0, 2048,     32'h0000_0013, 1'b1, 1);
        add_vec(3'd2, 5'd0, 5'd1, 5'd2, 3,        32'h0000_0013, 1'b1, 2);
        add_vec(3'd7, 5'd1, 5'd1, 5'd1, 0,        32'h0000_0013, 1'b1, 3);
        add_vec(3'd4, 5'd2, 5'd3, 5'd0, 2047,     32'h7FF1_8113, 1'b0, 3);
        add_vec(3'd4, 5'd2, 5'd3, 5'd0, -2048,    32'h8001_8113, 1'b0, 3);
        add_vec(3'd3, 5'd5, 5'd2, 5'd0, 4,        32'h0041_2283, 1'b0, 3);
        add_vec(3'd2, 5'd0, 5'd1, 5'd2, 4094,     32'h7E20_CFE3, 1'b0, 3);
        add_vec(3'd1, 5'd0, 5'd0, 5'd0, -4096,    32'h8000_0063, 1'b0, 3);
        add_vec(3'd0, 5'd1, 5'd0, 5'd0, 1048574,  32'h7FFF_F0EF, 1'b0, 3);
        add_vec(3'd0, 5'd0, 5'd0, 5'd0, -1048576, 32'h8000_006F, 1'b0, 3);
        add_vec(3'd5, 5'd0, 5'd2, 5'd3, -2048,    32'h8031_2023, 1'b0, 3);
        add_vec(3'd4, 5'd1, 5'd0, 5'd0, -2049,    32'h0000_0013, 1'b1, 4);
        add_vec(3'd1, 5'd0, 5'd1, 5'd2, 4096,     32'h0000_0013, 1'b1, 5);
        add_vec(3'd1, 5'd0, 5'd1, 5'd2, -4098,    32'h0000_0013, 1'b1, 6);
        add_vec(3'd0, 5'd1, 5'd0, 5'd0, 1048576,  32'h0000_0013, 1'b1, 7);
        add_vec(3'd0, 5'd1, 5'd0, 5'd0, 3,        32'h0000_0013, 1'b1, 8);
        add_vec(3'd5, 5'd0, 5'd1, 5'd2, 2048,     32'h0000_0013, 1'b1, 9);
        add_vec(3'd6, 5'd0, 5'd0, 5'd0, 0,        32'h0000_0013, 1'b1, 10);

        // reset state, then release between edges
        #12;
        check_cleared("reset");
        rst_n = 1'b1;
        cycle();
        check("ready_after_release", {31'd0, in_ready}, 32'd1);

        // backpressure: three back-to-back requests with the consumer stalled
        out_ready = 1'b0;
        set_req(1, 3'd4, 5'd1, 5'd0, 5'd0, 1); cycle();
        set_req(1, 3'd4, 5'd1, 5'd0, 5'd0, 2); cycle();
        check("bp_ready_low", {31'd0, in_ready}, 32'd0);
        set_req(1, 3'd4, 5'd1, 5'd0, 5'd0, 3); cycle();
        check("bp_head_stable", out_inst, 32'h0010_0093);
        check("bp_third_held", {16'd0, enc_cnt}, 32'd2);
        out_ready = 1'b1;
        cycle();
        check("bp_second", out_inst, 32'h0020_0093);
        cycle();
        check("bp_third", out_inst, 32'h0030_0093);
        in_valid = 1'b0;
        check("bp_enc_cnt", {16'd0, enc_cnt}, 32'd3);
        cycle();
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // reset with two results buffered
        out_ready = 1'b0;
        set_req(1, 3'd4, 5'd1, 5'd0, 5'd0, 4); cycle();
        set_req(1, 3'd4, 5'd1, 5'd0, 5'd0, 5); cycle();
        in_valid = 1'b0;
        check("rst_buffered", {16'd0, enc_cnt}, 32'd5);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_cleared("midrst");
        @(posedge clk); #1;
        compare_model();
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) cycle();
        check("no_stale", {31'd0, out_valid}, 32'd0);

        // directed vector table
        foreach (vecs[i]) begin
            set_req(1, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, int'(vecs[i].imm));
            cycle();
            in_valid = 1'b0;
            check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec%0d_inst", i), out_inst, vecs[i].inst);
            check($sformatf("vec%0d_err", i), {31'd0, out_err}, {31'd0, vecs[i].err});
            check($sformatf("vec%0d_errcnt", i), {24'd0, err_cnt}, vecs[i].errc);
            cycle();
        end

        // random traffic with random consumer stalls
        for (int n = 0; n < 1500; n++) begin
            int imm_v;
            case ($urandom % 4)
                0: imm_v = int'($urandom_range(0, 8191)) - 4096;
                1: imm_v = bnd[$urandom % 18];
                2: imm_v = int'($urandom);
                default: imm_v = int'($urandom_range(0, 4194303)) - 2097152;
            endcase
            set_req(($urandom % 4) != 0, 3'($urandom % 8), 5'($urandom), 5'($urandom),
                    5'($urandom), imm_v);
            out_ready = ($urandom % 3) != 0;
            cycle();
        end

        // counter limits from a fresh reset
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1 model_reset();
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        cycle();
        set_req(1, 3'd7, 5'd0, 5'd0, 5'd0, 0);
        repeat (300) cycle();
        check("err_cnt_saturated", {24'd0, err_cnt}, 32'd255);
        set_req(1, 3'd4, 5'd1, 5'd0, 5'd0, 0);
        repeat (65236) cycle();
        check("enc_cnt_wrapped", {16'd0, enc_cnt}, 32'd0);
        in_valid = 1'b0;
        repeat (2) cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
